fifo_csr_stream: RTL and testbench
==================================

Name: fifo_csr_stream

Overview:
- Parametrised single-clock data FIFO with an Avalon-MM CSR slave. It is the next generation of the rx/tx video and control FIFO endpoints between fabric converter logic and the HPS bridge.
- Adds over the fixed-width endpoints: generic data width and depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow events, a maskable interrupt and a flush control.
- Sits between a producer and a consumer in the same clock domain; software monitors and controls it through the CSR port.

Parameters:
- DATA_WIDTH, 8, width of write/read data words (1..32).
- DEPTH, 256, FIFO depth in words; power of two, 4..4096.
- AF_DEFAULT, DEPTH-4, reset value of the almost-full threshold.
- AE_DEFAULT, 4, reset value of the almost-empty threshold.

Ports:
- clk_clk  in  1  single clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- writedata_writedata  in  DATA_WIDTH  push data.
- writedata_write  in  1  push request.
- readdata_readdata  out  DATA_WIDTH  head-of-FIFO data (show-ahead).
- readdata_read  in  1  pop request.
- csr_address  in  3  CSR word address.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, registered.
- irq  out  1  level interrupt, equal to |(event & ienable).

Behaviour:
- Reset (async assert, sync release):
  - Pointers and level are 0.
  - event = 0, ienable = 0, af = AF_DEFAULT, ae = AE_DEFAULT.
  - csr_readdata = 0, irq = 0, readdata_readdata = 0.
- level width is clog2(DEPTH)+1; it ranges 0..DEPTH. full = (level==DEPTH), empty = (level==0).
- Push: accepted when write=1 and (!full or a pop is accepted in the same cycle). Push while full with no pop: data dropped, event.overflow set, level unchanged.
- Pop: accepted when read=1 and !empty. readdata_readdata shows the head word combinationally while !empty and is 0 while empty. Pop while empty: event.underflow set; a simultaneous push is still accepted but is not visible to that pop (no fall-through).
- Push and pop in the same cycle, both accepted: level unchanged, including the full case.
- Pointers wrap modulo DEPTH.
- Pushed data appears at readdata_readdata on the next cycle if the FIFO was empty.
- Status (combinational):
  - bit0 full, bit1 empty.
  - bit2 almost_full = (level >= af).
  - bit3 almost_empty = (level <= ae).
  - bit4 overflow and bit5 underflow are single-cycle pulses.
- Event register: bits 0..5 are sticky versions of the status bits. A bit is set on any cycle its status bit is 1. Write-1-to-clear; when a set and a clear hit the same cycle, set wins.
- CSR map (word address):
  - 0: fill level (RO).
  - 1: status (RO).
  - 2: event (W1C).
  - 3: ienable [5:0] (RW).
  - 4: af threshold (RW).
  - 5: ae threshold (RW).
  - 6: control (WO); writing bit0=1 flushes.
  - 7: reserved, reads 0.
  - Threshold registers hold clog2(DEPTH)+1 bits; upper write bits are ignored.
- CSR read latency is 1 cycle: csr_readdata is registered on csr_read and holds its value otherwise. Unused bits read 0.
- Flush: in the cycle after the control write, pointers and level are 0. A push or pop in the flush-write cycle is discarded, and no overflow/underflow is flagged for it. Flush does not clear event, ienable or thresholds.
- irq is registered: it asserts 1 cycle after the event bit sets and deasserts 1 cycle after the clear or mask.
- Reset mid-operation: all state returns to reset values immediately; data in flight is lost.

Test Plan:
- Push 0x01..0x10 (16 words), then pop 16 -> data returns in order 0x01..0x10; level goes 16 -> 0; empty=1 at end; event.almost_empty set.
- Fill to DEPTH=256, push 0xAA again -> dropped; status full=1; event bit4 = 1; irq=1 if ienable=0x10; after writing 0x10 to addr 2, irq=0 within 1 cycle.
- FIFO full, push 0x55 and pop in the same cycle -> level stays 256; 0x55 is the last word read out.
- Empty FIFO, pop and push 0x33 in the same cycle -> underflow event set; level=1; next pop returns 0x33.
- Write af=10, push 10 words -> almost_full rises exactly on the 10th push; write control=1 -> level=0 next cycle; af still reads back 10.
- Assert reset_reset_n=0 mid-burst at level=37 -> level, event and irq are 0 immediately; csr_readdata=0; af reads back AF_DEFAULT after release.

Source files
------------

// File: rtl/fifo_csr_stream.sv
// Single-clock show-ahead data FIFO with an Avalon-MM CSR slave: fill level,
// status, sticky W1C events, interrupt enable, programmable thresholds and flush.
module fifo_csr_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256,
   parameter int AF_DEFAULT = DEPTH - 4,
   parameter int AE_DEFAULT = 4
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [DATA_WIDTH-1:0] writedata_writedata,
   input  logic                  writedata_write,
   output logic [DATA_WIDTH-1:0] readdata_readdata,
   input  logic                  readdata_read,
   input  logic [2:0]            csr_address,
   input  logic                  csr_read,
   input  logic                  csr_write,
   input  logic [31:0]           csr_writedata,
   output logic [31:0]           csr_readdata,
   output logic                  irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d, af_q, af_d, ae_q, ae_d;
   logic [5:0]    event_q, event_d, ienable_q, ienable_d, status_s, clear_s;
   logic [31:0]   csr_rdata_q, csr_rdata_d, csr_mux_s;
   logic          irq_q, irq_d;
   logic          full_s, empty_s, flush_s, push_s, pop_s, ovf_s, udf_s;
   logic          unused_s;

   assign unused_s = ^csr_writedata[31:LW];

   // Handshake qualification; a flush swallows any push/pop in its cycle.
   always_comb begin
      full_s   = (level_q == DEPTH_L);
      empty_s  = (level_q == {LW{1'b0}});
      flush_s  = csr_write && (csr_address == 3'd6) && csr_writedata[0];
      pop_s    = readdata_read && !empty_s && !flush_s;
      push_s   = writedata_write && (!full_s || pop_s) && !flush_s;
      ovf_s    = writedata_write && full_s && !readdata_read && !flush_s;
      udf_s    = readdata_read && empty_s && !flush_s;
      status_s = {udf_s, ovf_s, (level_q <= ae_q), (level_q >= af_q), empty_s, full_s};
   end

   // Next-state for pointers, level and the CSR-visible registers.
   always_comb begin
      wr_ptr_d  = flush_s ? {AW{1'b0}} : (push_s ? wr_ptr_q + AW'(1) : wr_ptr_q);
      rd_ptr_d  = flush_s ? {AW{1'b0}} : (pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q);
      level_d   = flush_s ? {LW{1'b0}} : (level_q + LW'(push_s) - LW'(pop_s));
      clear_s   = (csr_write && (csr_address == 3'd2)) ? csr_writedata[5:0] : 6'd0;
      event_d   = (event_q & ~clear_s) | status_s;
      ienable_d = (csr_write && (csr_address == 3'd3)) ? csr_writedata[5:0] : ienable_q;
      af_d      = (csr_write && (csr_address == 3'd4)) ? csr_writedata[LW-1:0] : af_q;
      ae_d      = (csr_write && (csr_address == 3'd5)) ? csr_writedata[LW-1:0] : ae_q;
      irq_d     = |(event_q & ienable_q);
   end

   // CSR read multiplexer; unmapped and write-only addresses read as zero.
   always_comb begin
      csr_mux_s = 32'd0;
      case (csr_address)
         3'd0:    csr_mux_s = {{(32-LW){1'b0}}, level_q};
         3'd1:    csr_mux_s = {26'd0, status_s};
         3'd2:    csr_mux_s = {26'd0, event_q};
         3'd3:    csr_mux_s = {26'd0, ienable_q};
         3'd4:    csr_mux_s = {{(32-LW){1'b0}}, af_q};
         3'd5:    csr_mux_s = {{(32-LW){1'b0}}, ae_q};
         default: csr_mux_s = 32'd0;
      endcase
      csr_rdata_d = csr_read ? csr_mux_s : csr_rdata_q;
   end

   // State registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= {LW{1'b0}};
         event_q     <= 6'd0;
         ienable_q   <= 6'd0;
         af_q        <= LW'(AF_DEFAULT);
         ae_q        <= LW'(AE_DEFAULT);
         csr_rdata_q <= 32'd0;
         irq_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         event_q     <= event_d;
         ienable_q   <= ienable_d;
         af_q        <= af_d;
         ae_q        <= ae_d;
         csr_rdata_q <= csr_rdata_d;
         irq_q       <= irq_d;
      end
   end

   // Storage array, no reset: contents are only visible through the level.
   always_ff @(posedge clk_clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= writedata_writedata;
      end
   end

   assign readdata_readdata = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign csr_readdata      = csr_rdata_q;
   assign irq               = irq_q;

endmodule

// File: tb/tb_fifo_csr_stream.sv
// Directed bench for fifo_csr_stream (DATA_WIDTH=8, DEPTH=256): a vector table
// for the basic push/pop/CSR flow plus hand sequences for full, flush and reset.
module tb_fifo_csr_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  wdata = 8'd0;
   logic        wr = 1'b0;
   logic [7:0]  rdata;
   logic        rd = 1'b0;
   logic [2:0]  caddr = 3'd0;
   logic        cread = 1'b0;
   logic        cwrite = 1'b0;
   logic [31:0] cwdata = 32'd0;
   logic [31:0] crdata;
   logic        irq_o;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  wd;
      logic        rd;
      logic        cr;
      logic [2:0]  ca;
      logic        chk_rd;
      logic [7:0]  exp_rd;
      logic        chk_csr;
      logic [31:0] exp_csr;
   } vec_t;

   vec_t tbl [64];
   int   n_vec = 0;

   fifo_csr_stream #(.DATA_WIDTH(8), .DEPTH(256)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .writedata_writedata(wdata), .writedata_write(wr),
      .readdata_readdata(rdata), .readdata_read(rd),
      .csr_address(caddr), .csr_read(cread), .csr_write(cwrite),
      .csr_writedata(cwdata), .csr_readdata(crdata), .irq(irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   // Drive one cycle of inputs (called 1 ns after a rising edge), then idle them.
   task automatic step(input logic w, input logic [7:0] wd, input logic r,
                       input logic cw, input logic cr, input logic [2:0] ca,
                       input logic [31:0] cd);
      wr = w; wdata = wd; rd = r; cwrite = cw; cread = cr; caddr = ca; cwdata = cd;
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; cwrite = 1'b0; cread = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);   step(1'b1, d, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0); endtask
   task automatic pop();                       step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0); endtask
   task automatic idle();                      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0); endtask
   task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, a, d);
   endtask
   task automatic csr_rd(input logic [2:0] a); step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, a, 32'd0); endtask

   task automatic add(input logic w, input logic [7:0] wd, input logic r, input logic cr,
                      input logic [2:0] ca, input logic crd, input logic [7:0] erd,
                      input logic ccs, input logic [31:0] ecs);
      tbl[n_vec] = '{w, wd, r, cr, ca, crd, erd, ccs, ecs};
      n_vec++;
   endtask

   initial begin
      // Vector table: reset-state CSR reads, 16 pushes, 16 in-order pops.
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd4, 1'b0, 8'd0, 1'b1, 32'd252);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd5, 1'b0, 8'd0, 1'b1, 32'd4);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, 1'b1, 32'd0);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'd0, 1'b1, 32'h0A);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0, 1'b1, 32'h0A);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd3, 1'b0, 8'd0, 1'b1, 32'd0);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd7, 1'b0, 8'd0, 1'b1, 32'd0);
      for (int i = 1; i <= 16; i++) add(1'b1, 8'(i), 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 32'd0);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b0, 8'd0, 1'b1, 32'd16);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'd0, 1'b1, 32'h00);
      for (int i = 1; i <= 16; i++) add(1'b0, 8'd0, 1'b1, 1'b0, 3'd0, 1'b1, 8'(i), 1'b0, 32'd0);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0, 1'b1, 32'd0);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'd0, 1'b1, 32'h0A);
      add(1'b0, 8'd0, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0, 1'b1, 32'h0A);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_readdata", {24'd0, rdata}, 32'd0);
      chk("reset_irq", {31'd0, irq_o}, 32'd0);
      chk("reset_csr_readdata", crdata, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < n_vec; i++) begin
         if (tbl[i].chk_rd) chk($sformatf("vec%0d_readdata", i), {24'd0, rdata}, {24'd0, tbl[i].exp_rd});
         step(tbl[i].wr, tbl[i].wd, tbl[i].rd, 1'b0, tbl[i].cr, tbl[i].ca, 32'd0);
         if (tbl[i].chk_csr) chk($sformatf("vec%0d_csr", i), crdata, tbl[i].exp_csr);
      end

      // Fill to DEPTH, overflow, interrupt, W1C.
      csr_wr(3'd3, 32'h10);
      for (int i = 0; i < 256; i++) push(8'(i));
      csr_rd(3'd1);
      chk("full_status", crdata, 32'h05);
      push(8'hAA);
      csr_rd(3'd2);
      chk("ovf_event", crdata, 32'h1F);
      chk("ovf_irq", {31'd0, irq_o}, 32'd1);
      csr_rd(3'd0);
      chk("ovf_level", crdata, 32'h100);
      csr_wr(3'd2, 32'h10);
      idle();
      chk("irq_cleared", {31'd0, irq_o}, 32'd0);
      csr_rd(3'd2);
      chk("event_after_w1c", crdata, 32'h0F);

      // Full: push and pop together, then drain.
      chk("full_head", {24'd0, rdata}, 32'h00);
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
      csr_rd(3'd0);
      chk("full_pushpop_level", crdata, 32'h100);
      for (int i = 1; i < 256; i++) begin
         chk($sformatf("drain_%0d", i), {24'd0, rdata}, 32'(i));
         pop();
      end
      chk("drain_last_55", {24'd0, rdata}, 32'h55);
      pop();
      csr_rd(3'd0);
      chk("drained_level", crdata, 32'd0);
      chk("empty_readdata", {24'd0, rdata}, 32'd0);

      // Empty: pop with simultaneous push, no fall-through.
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
      csr_rd(3'd2);
      chk("udf_event", crdata, 32'h2F);
      csr_rd(3'd0);
      chk("udf_level", crdata, 32'd1);
      chk("udf_irq_masked", {31'd0, irq_o}, 32'd0);
      chk("udf_head_33", {24'd0, rdata}, 32'h33);
      pop();

      // Almost-full threshold and flush with a discarded push.
      csr_wr(3'd4, 32'd10);
      csr_rd(3'd4);
      chk("af_readback", crdata, 32'd10);
      for (int k = 1; k <= 10; k++) begin
         push(8'(k));
         csr_rd(3'd1);
         chk($sformatf("af_status_%0d", k), crdata, ((k <= 4) ? 32'h08 : 32'h00) | ((k >= 10) ? 32'h04 : 32'h00));
      end
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 3'd6, 32'd1);
      chk("flush_readdata", {24'd0, rdata}, 32'd0);
      csr_rd(3'd0);
      chk("flush_level", crdata, 32'd0);
      csr_rd(3'd4);
      chk("flush_af_kept", crdata, 32'd10);

      // Reset in the middle of a burst at level 37.
      csr_wr(3'd3, 32'h02);
      idle();
      chk("irq_empty_enabled", {31'd0, irq_o}, 32'd1);
      for (int j = 0; j < 37; j++) push(8'h80 + 8'(j));
      csr_rd(3'd0);
      chk("burst_level", crdata, 32'd37);
      chk("burst_head", {24'd0, rdata}, 32'h80);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_readdata", {24'd0, rdata}, 32'd0);
      chk("midreset_irq", {31'd0, irq_o}, 32'd0);
      chk("midreset_csr", crdata, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      csr_rd(3'd2);
      chk("postreset_event", crdata, 32'd0);
      csr_rd(3'd4);
      chk("postreset_af", crdata, 32'd252);
      csr_rd(3'd0);
      chk("postreset_level", crdata, 32'd0);
      chk("postreset_irq", {31'd0, irq_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
